// File: rtl/axi_mst_pt_mem_chip_if.sv
// AXI4-Lite bus bundle shared by the traffic master, the passthrough monitor and the memory slave.
interface axi_mst_pt_mem_chip_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_mst_pt_mem_chip.sv
// AXI4-Lite self-test subsystem: traffic master -> counting passthrough -> word memory slave.
// The master writes NUM_TXN words, reads them back and reports done/pass/err_cnt.
module axi_mst_pt_mem_chip_mst #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                NUM_TXN   = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   axi_mst_pt_mem_chip_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [7:0]            err_cnt
);
   typedef enum logic [2:0] {S_IDLE, S_WA, S_WB, S_RA, S_RD, S_DONE} state_t;

   state_t      state;
   logic [7:0]  idx;
   logic        aw_v, w_v, b_rdy, ar_v, r_rdy;
   logic        last;
   logic [7:0]  err_inc;
   logic [DATA_W-1:0] pattern;

   assign pattern      = DATA_W'(32'hDEAD_0000) + DATA_W'(idx);
   assign last         = (idx == 8'(NUM_TXN - 1));
   assign err_inc      = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
   assign bus.awaddr   = BASE_ADDR + (ADDR_W'(idx) << 2);
   assign bus.araddr   = BASE_ADDR + (ADDR_W'(idx) << 2);
   assign bus.wdata    = pattern;
   assign bus.wstrb    = '1;
   assign bus.awvalid  = aw_v;
   assign bus.wvalid   = w_v;
   assign bus.bready   = b_rdy;
   assign bus.arvalid  = ar_v;
   assign bus.rready   = r_rdy;
   assign pass         = done && (err_cnt == 8'd0);

   // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err_cnt <= '0;
         aw_v    <= 1'b0;
         w_v     <= 1'b0;
         b_rdy   <= 1'b0;
         ar_v    <= 1'b0;
         r_rdy   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state   <= S_WA;
                  idx     <= '0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  err_cnt <= '0;
                  aw_v    <= 1'b1;
                  w_v     <= 1'b1;
               end
            end
            S_WA: begin
               // Address and data may be accepted in different cycles; each valid drops on its own.
               if (bus.awready) aw_v <= 1'b0;
               if (bus.wready)  w_v  <= 1'b0;
               if ((!aw_v || bus.awready) && (!w_v || bus.wready)) begin
                  state <= S_WB;
                  b_rdy <= 1'b1;
               end
            end
            S_WB: begin
               if (bus.bvalid) begin
                  b_rdy <= 1'b0;
                  if (bus.bresp != 2'b00) err_cnt <= err_inc;
                  if (last) begin
                     idx   <= '0;
                     state <= S_RA;
                     ar_v  <= 1'b1;
                  end else begin
                     idx   <= idx + 8'd1;
                     state <= S_WA;
                     aw_v  <= 1'b1;
                     w_v   <= 1'b1;
                  end
               end
            end
            S_RA: begin
               if (bus.arready) begin
                  ar_v  <= 1'b0;
                  r_rdy <= 1'b1;
                  state <= S_RD;
               end
            end
            S_RD: begin
               if (bus.rvalid) begin
                  r_rdy <= 1'b0;
                  if (bus.rresp != 2'b00 || bus.rdata != pattern) err_cnt <= err_inc;
                  if (last) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     idx   <= idx + 8'd1;
                     state <= S_RA;
                     ar_v  <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

module axi_mst_pt_mem_chip_pt (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   axi_mst_pt_mem_chip_if.slave  up,
   axi_mst_pt_mem_chip_if.master dn,
   output logic [15:0]           wr_cnt,
   output logic [15:0]           rd_cnt
);
   assign dn.awaddr  = up.awaddr;
   assign dn.awvalid = up.awvalid;
   assign up.awready = dn.awready;
   assign dn.wdata   = up.wdata;
   assign dn.wstrb   = up.wstrb;
   assign dn.wvalid  = up.wvalid;
   assign up.wready  = dn.wready;
   assign up.bresp   = dn.bresp;
   assign up.bvalid  = dn.bvalid;
   assign dn.bready  = up.bready;
   assign dn.araddr  = up.araddr;
   assign dn.arvalid = up.arvalid;
   assign up.arready = dn.arready;
   assign up.rdata   = dn.rdata;
   assign up.rresp   = dn.rresp;
   assign up.rvalid  = dn.rvalid;
   assign dn.rready  = up.rready;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (dn.bvalid && dn.bready) wr_cnt <= wr_cnt + 16'd1;
         if (dn.rvalid && dn.rready) rd_cnt <= rd_cnt + 16'd1;
      end
   end
endmodule

module axi_mst_pt_mem_chip_slv #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                MEM_WORDS = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   axi_mst_pt_mem_chip_if.slave bus
);
   localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [MEM_WORDS];
   logic              aw_held, w_held, bvalid_q, rvalid_q;
   logic [ADDR_W-1:0] aw_addr_q;
   logic [DATA_W-1:0] w_data_q, rdata_q;
   logic [NB-1:0]     w_strb_q;
   logic [1:0]        bresp_q, rresp_q;
   logic              aw_hs, w_hs, ar_hs, wr_fire, wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [NB-1:0]     wr_strb;

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a[1:0] == 2'b00) && (((a - BASE_ADDR) >> 2) < ADDR_W'(MEM_WORDS));
   endfunction

   function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IW'((a - BASE_ADDR) >> 2);
   endfunction

   assign bus.awready = !aw_held && !bvalid_q;
   assign bus.wready  = !w_held && !bvalid_q;
   assign bus.arready = !rvalid_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rresp   = rresp_q;
   assign bus.rdata   = rdata_q;

   assign aw_hs   = bus.awvalid && bus.awready;
   assign w_hs    = bus.wvalid && bus.wready;
   assign ar_hs   = bus.arvalid && bus.arready;
   assign wr_addr = aw_held ? aw_addr_q : bus.awaddr;
   assign wr_data = w_held ? w_data_q : bus.wdata;
   assign wr_strb = w_held ? w_strb_q : bus.wstrb;
   // A write commits the cycle its second half arrives, so B follows one cycle later.
   assign wr_fire = (aw_held || aw_hs) && (w_held || w_hs);
   assign wr_en   = wr_fire && addr_ok(wr_addr);

   // NOTE: the storage array has no reset; contents deliberately survive a reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++)
            if (wr_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (aw_hs) aw_addr_q <= bus.awaddr;
         if (w_hs) begin
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
         end
         if (bvalid_q && bus.bready) bvalid_q <= 1'b0;
         if (wr_fire) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= addr_ok(wr_addr) ? 2'b00 : 2'b10;
         end else begin
            if (aw_hs) aw_held <= 1'b1;
            if (w_hs)  w_held  <= 1'b1;
         end
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= addr_ok(bus.araddr) ? 2'b00 : 2'b10;
            rdata_q  <= addr_ok(bus.araddr) ? mem[word_idx(bus.araddr)] : '0;
         end else if (rvalid_q && bus.rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end
endmodule

module axi_mst_pt_mem_chip #(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                MEM_WORDS = 16,
   parameter int                NUM_TXN   = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic        aclk,
   input  logic        aresetn,   // active-high synchronous reset despite the name
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  err_cnt,
   output logic [15:0] wr_cnt,
   output logic [15:0] rd_cnt
);
   axi_mst_pt_mem_chip_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();
   axi_mst_pt_mem_chip_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

   logic run_start;
   assign run_start = start && !busy;

   axi_mst_pt_mem_chip_mst #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_TXN(NUM_TXN), .BASE_ADDR(BASE_ADDR)
   ) u_mst (
      .clk(aclk), .rst(aresetn), .start(start), .bus(m_bus.master),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
   );

   axi_mst_pt_mem_chip_pt u_pt (
      .clk(aclk), .rst(aresetn), .clr(run_start),
      .up(m_bus.slave), .dn(s_bus.master), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
   );

   axi_mst_pt_mem_chip_slv #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)
   ) u_slv (
      .clk(aclk), .rst(aresetn), .bus(s_bus.slave)
   );
endmodule

// File: tb/tb_axi_mst_pt_mem_chip.sv
// Scoreboard bench: three chip variants (default, 4-word memory, unaligned base) driven by one start.
// Expected run results and read beats come from a word-level model of the write/readback test.
module tb_axi_mst_pt_mem_chip;
   localparam int ND = 3;
   localparam int NT = 8;

   typedef struct packed {
      logic        pass_b;
      logic [7:0]  err;
      logic [15:0] wr;
      logic [15:0] rd;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        aresetn, start;
   logic        busy_v [ND];
   logic        done_v [ND];
   logic        pass_v [ND];
   logic [7:0]  err_v  [ND];
   logic [15:0] wr_v   [ND];
   logic [15:0] rd_v   [ND];

   int n_chk  = 0;
   int n_pass = 0;

   res_t        exp_q [ND][$];
   logic [33:0] rq[$];
   logic [31:0] mmem [ND][16];
   int unsigned base_p  [ND];
   int unsigned words_p [ND];

   axi_mst_pt_mem_chip dut (
      .aclk(clk), .aresetn(aresetn), .start(start), .busy(busy_v[0]), .done(done_v[0]),
      .pass(pass_v[0]), .err_cnt(err_v[0]), .wr_cnt(wr_v[0]), .rd_cnt(rd_v[0]));
   axi_mst_pt_mem_chip #(.MEM_WORDS(4)) dut_small (
      .aclk(clk), .aresetn(aresetn), .start(start), .busy(busy_v[1]), .done(done_v[1]),
      .pass(pass_v[1]), .err_cnt(err_v[1]), .wr_cnt(wr_v[1]), .rd_cnt(rd_v[1]));
   axi_mst_pt_mem_chip #(.BASE_ADDR(32'h0000_0002)) dut_unal (
      .aclk(clk), .aresetn(aresetn), .start(start), .busy(busy_v[2]), .done(done_v[2]),
      .pass(pass_v[2]), .err_cnt(err_v[2]), .wr_cnt(wr_v[2]), .rd_cnt(rd_v[2]));

   // Observation copy of the default chip's slave-side bus.
   axi_mst_pt_mem_chip_if #(.ADDR_W(32), .DATA_W(32)) mon_if ();
   assign mon_if.awaddr  = dut.s_bus.awaddr;
   assign mon_if.awvalid = dut.s_bus.awvalid;
   assign mon_if.awready = dut.s_bus.awready;
   assign mon_if.wdata   = dut.s_bus.wdata;
   assign mon_if.wstrb   = dut.s_bus.wstrb;
   assign mon_if.wvalid  = dut.s_bus.wvalid;
   assign mon_if.wready  = dut.s_bus.wready;
   assign mon_if.bresp   = dut.s_bus.bresp;
   assign mon_if.bvalid  = dut.s_bus.bvalid;
   assign mon_if.bready  = dut.s_bus.bready;
   assign mon_if.araddr  = dut.s_bus.araddr;
   assign mon_if.arvalid = dut.s_bus.arvalid;
   assign mon_if.arready = dut.s_bus.arready;
   assign mon_if.rdata   = dut.s_bus.rdata;
   assign mon_if.rresp   = dut.s_bus.rresp;
   assign mon_if.rvalid  = dut.s_bus.rvalid;
   assign mon_if.rready  = dut.s_bus.rready;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Whole-run model: write pattern words, read them back, count bad responses and mismatches.
   task automatic model_run(input int d);
      res_t        r;
      int          err = 0;
      int unsigned a, off;
      logic [31:0] data;
      bit          ok;
      for (int i = 0; i < NT; i++) begin
         a   = base_p[d] + 4 * i;
         off = a - base_p[d];
         ok  = (a % 4 == 0) && (off / 4 < words_p[d]);
         if (ok) mmem[d][off / 4] = 32'hDEAD_0000 + i;
         else err++;
      end
      for (int i = 0; i < NT; i++) begin
         a    = base_p[d] + 4 * i;
         off  = a - base_p[d];
         ok   = (a % 4 == 0) && (off / 4 < words_p[d]);
         data = ok ? mmem[d][off / 4] : 32'h0;
         if (d == 0) rq.push_back({ok ? 2'b00 : 2'b10, data});
         if (!ok || data != 32'hDEAD_0000 + i) err++;
      end
      if (err > 255) err = 255;
      r.pass_b = (err == 0);
      r.err    = 8'(err);
      r.wr     = 16'(NT);
      r.rd     = 16'(NT);
      exp_q[d].push_back(r);
   endtask

   // Monitor: compares run results on each rising done and every R beat of the default chip.
   logic        done_prev [ND];
   res_t        got_r;
   logic [33:0] got_e;
   initial for (int d = 0; d < ND; d++) done_prev[d] = 1'b0;

   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (done_v[d] && !done_prev[d]) begin
            check($sformatf("dut%0d run expected", d), 64'(exp_q[d].size() > 0), 64'd1);
            if (exp_q[d].size() > 0) begin
               got_r = exp_q[d].pop_front();
               check($sformatf("dut%0d pass", d), 64'(pass_v[d]), 64'(got_r.pass_b));
               check($sformatf("dut%0d err_cnt", d), 64'(err_v[d]), 64'(got_r.err));
               check($sformatf("dut%0d wr_cnt", d), 64'(wr_v[d]), 64'(got_r.wr));
               check($sformatf("dut%0d rd_cnt", d), 64'(rd_v[d]), 64'(got_r.rd));
            end
         end
         done_prev[d] <= done_v[d];
      end
      if (mon_if.rvalid && mon_if.rready) begin
         check("R beat expected", 64'(rq.size() > 0), 64'd1);
         if (rq.size() > 0) begin
            got_e = rq.pop_front();
            check("R beat resp/data", 64'({mon_if.rresp, mon_if.rdata}), 64'(got_e));
         end
      end
   end

   task automatic issue_start();
      @(posedge clk); #1;
      start = 1'b1;
      for (int d = 0; d < ND; d++) model_run(d);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Holds start asserted every cycle (or randomly) while the run is busy.
   task automatic issue_start_spam(input bit random_mode);
      @(posedge clk); #1;
      start = 1'b1;
      for (int d = 0; d < ND; d++) model_run(d);
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (!busy_v[0]) break;
         start = random_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string name);
      int n = 0;
      while (!(done_v[0] && done_v[1] && done_v[2]) && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, " done within budget"}, 64'(done_v[0] && done_v[1] && done_v[2]), 64'd1);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      for (int d = 0; d < ND; d++) begin
         check($sformatf("%s dut%0d busy", tag, d), 64'(busy_v[d]), 64'd0);
         check($sformatf("%s dut%0d done", tag, d), 64'(done_v[d]), 64'd0);
         check($sformatf("%s dut%0d pass", tag, d), 64'(pass_v[d]), 64'd0);
         check($sformatf("%s dut%0d err_cnt", tag, d), 64'(err_v[d]), 64'd0);
         check($sformatf("%s dut%0d wr_cnt", tag, d), 64'(wr_v[d]), 64'd0);
         check($sformatf("%s dut%0d rd_cnt", tag, d), 64'(rd_v[d]), 64'd0);
      end
      check({tag, " valids"}, 64'({mon_if.awvalid, mon_if.wvalid, mon_if.bvalid,
                                   mon_if.arvalid, mon_if.rvalid}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      base_p  = '{32'h0, 32'h0, 32'h2};
      words_p = '{16, 4, 16};
      aresetn = 1'b1;
      start   = 1'b0;
      repeat (5) @(posedge clk);
      #1 aresetn = 1'b0;
      @(negedge clk);
      check_idle("reset");

      issue_start();
      wait_done(40, "run1");

      repeat ($urandom_range(1, 6)) @(posedge clk);
      issue_start();
      wait_done(40, "run2");
      check("mem word 3", 64'(dut.u_slv.mem[3]), 64'h0000_0000_DEAD_0003);

      // Reset pulse while the fourth write is in flight.
      issue_start();
      nb = 0;
      for (int c = 0; c < 40 && nb < 3; c++) begin
         @(negedge clk);
         if (mon_if.bvalid && mon_if.bready) nb++;
      end
      check("reached write 3", 64'(nb), 64'd3);
      @(posedge clk); #1;
      aresetn = 1'b1;
      for (int d = 0; d < ND; d++) exp_q[d].delete();
      rq.delete();
      @(posedge clk); #1;
      aresetn = 1'b0;
      @(negedge clk);
      check_idle("mid-run reset");
      issue_start();
      wait_done(40, "after reset");

      issue_start_spam(1'b0);
      wait_done(40, "start spam");
      repeat (3) @(posedge clk);
      #1;
      check("spam no restart busy", 64'(busy_v[0]), 64'd0);
      check("spam still done", 64'(done_v[0]), 64'd1);

      for (int k = 0; k < 2; k++) begin
         repeat ($urandom_range(0, 5)) @(posedge clk);
         issue_start_spam(1'b1);
         wait_done(40, $sformatf("random run %0d", k));
      end

      repeat (2) @(negedge clk);
      for (int d = 0; d < ND; d++)
         check($sformatf("dut%0d runs drained", d), 64'(exp_q[d].size()), 64'd0);
      check("R beats drained", 64'(rq.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
